// File: rtl/silife_matrix.sv
// 8x8 Conway Game-of-Life matrix with row write (OR-set) and row readback.
// Define SILIFE_WRAP_EN for toroidal neighbour lookup; default is a bounded plane.
module silife_matrix (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] row_select,
  input  logic [7:0] set_cells,
  output logic [7:0] cells
);

  logic [7:0][7:0] cell_q;
  logic [7:0][7:0] cell_d;
  logic [3:0]      cnt;

  // Returns the state of the cell at (r, c), where r and c may be -1 or 8.
  function automatic logic cell_at(input logic [7:0][7:0] m, input int r, input int c);
    logic [2:0] rr;
    logic [2:0] cc;
    rr = 3'(r);
    cc = 3'(c);
`ifdef SILIFE_WRAP_EN
    // Truncating to 3 bits maps -1 to 7 and 8 to 0, which is exactly the torus.
    return m[rr][cc];
`else
    if (r < 0 || r > 7 || c < 0 || c > 7) return 1'b0;
    return m[rr][cc];
`endif
  endfunction

  always_comb begin
    cell_d = cell_q;
    cnt    = '0;
    if (set_cells != 8'h00) begin
      // A write wins over a generation step on the same edge.
      cell_d[row_select] = cell_q[row_select] | set_cells;
    end else if (enable) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          cnt = '0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              if (dr != 0 || dc != 0)
                cnt = cnt + {3'b000, cell_at(cell_q, r + dr, c + dc)};
            end
          end
          if (cell_q[r][c])
            cell_d[r][c] = (cnt == 4'd2) || (cnt == 4'd3);
          else
            cell_d[r][c] = (cnt == 4'd3);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cell_q <= '0;
    else       cell_q <= cell_d;
  end

  assign cells = cell_q[row_select];

endmodule

// File: tb/tb_silife_matrix.sv
// Bench for silife_matrix: directed Life patterns plus randomized writes/steps
// compared against a grid model in the bench.
`timescale 1ns/100ps
module tb_silife_matrix;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] row_select;
  logic [7:0] set_cells;
  logic [7:0] cells;

  int checks = 0;
  int errors = 0;

  int mdl [8][8];
  logic [7:0] exp_q[$];

  silife_matrix dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .row_select (row_select),
    .set_cells  (set_cells),
    .cells      (cells)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // reference model
  task automatic model_clear();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = 0;
  endtask

  task automatic model_step();
    int nxt [8][8];
    int n, rr, cc;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
`ifdef SILIFE_WRAP_EN
            rr = (rr + 8) % 8;
            cc = (cc + 8) % 8;
`else
            if (rr < 0 || rr > 7 || cc < 0 || cc > 7) continue;
`endif
            n += mdl[rr][cc];
          end
        end
        nxt[r][c] = (n == 3 || (mdl[r][c] == 1 && n == 2)) ? 1 : 0;
      end
    end
    mdl = nxt;
  endtask

  function automatic logic [7:0] model_row(input int r);
    logic [7:0] v;
    for (int c = 0; c < 8; c++) v[c] = (mdl[r][c] != 0);
    return v;
  endfunction

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick(input logic en, input logic [2:0] row, input logic [7:0] mask);
    enable     = en;
    row_select = row;
    set_cells  = mask;
    @(posedge clk);
    if (!reset) begin
      if (mask != 8'h00) begin
        for (int c = 0; c < 8; c++) if (mask[c]) mdl[row][c] = 1;
      end else if (en) begin
        model_step();
      end
    end
    #1;
    enable    = 1'b0;
    set_cells = 8'h00;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 3'd0, 8'h00);
  endtask

  // scoreboard
  task automatic check_rows(input string tag);
    logic [7:0] exp;
    for (int r = 0; r < 8; r++) begin
      row_select = 3'(r);
      exp_q.push_back(model_row(r));
      #1;
      exp = exp_q.pop_front();
      checks++;
      assert (cells === exp) else begin
        errors++;
        $error("FAIL %s row %0d observed %h expected %h", tag, r, cells, exp);
      end
    end
  endtask

  task automatic check_const(input string tag, input int r, input logic [7:0] exp);
    row_select = 3'(r);
    #1;
    checks++;
    assert (cells === exp) else begin
      errors++;
      $error("FAIL %s row %0d observed %h expected %h", tag, r, cells, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int nw, ns;
    logic [7:0] m;
    reset      = 1'b1;
    enable     = 1'b0;
    row_select = 3'd0;
    set_cells  = 8'h00;
    model_clear();
    #3;
    for (int r = 0; r < 8; r++) check_const("reset_zero", r, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // blinker
    tick(1'b0, 3'd4, 8'h70);
    check_const("blinker_load", 4, 8'h70);
    check_rows("blinker_load_all");
    steps(1);
    check_const("blinker_v3", 3, 8'h20);
    check_const("blinker_v4", 4, 8'h20);
    check_const("blinker_v5", 5, 8'h20);
    check_rows("blinker_gen1");
    steps(1);
    check_const("blinker_h4", 4, 8'h70);
    check_rows("blinker_gen2");

    // hold with enable low, then write beats step
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd0, 8'h00);
    check_const("hold_row4", 4, 8'h70);
    check_rows("hold_all");
    tick(1'b1, 3'd0, 8'h80);
    check_const("write_prio_row4", 4, 8'h70);
    check_const("write_prio_row0", 0, 8'h80);
    check_rows("write_prio_all");

    // reset between edges mid-blinker
    do_reset();
    tick(1'b0, 3'd4, 8'h70);
    steps(1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    for (int r = 0; r < 8; r++) check_const("async_reset", r, 8'h00);
    tick(1'b1, 3'd2, 8'hFF);
    check_rows("write_ignored_in_reset");
    reset = 1'b0;

    // block still life at the corner
    tick(1'b0, 3'd0, 8'h03);
    tick(1'b0, 3'd1, 8'h03);
    steps(4);
    check_const("block_r0", 0, 8'h03);
    check_const("block_r1", 1, 8'h03);
    check_rows("block_all");

    // edge behaviour
    do_reset();
    tick(1'b0, 3'd0, 8'h07);
    steps(1);
    check_const("edge_r0", 0, 8'h02);
    check_const("edge_r1", 1, 8'h02);
`ifdef SILIFE_WRAP_EN
    check_const("edge_r7", 7, 8'h02);
`else
    check_const("edge_r7", 7, 8'h00);
`endif
    check_rows("edge_all");

    // empty stays empty, full row accepted
    do_reset();
    steps(3);
    check_rows("empty_steps");
    tick(1'b0, 3'd3, 8'hFF);
    check_const("full_row", 3, 8'hFF);
    steps(1);
    check_rows("full_row_step");

    // randomized writes and steps
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 5) == 0) do_reset();
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        m = 8'($urandom_range(1, 255));
        tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), m);
      end
      ns = $urandom_range(0, 4);
      for (int s = 0; s < ns; s++) tick(1'($urandom_range(0, 3) != 0), 3'd0, 8'h00);
      check_rows("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
